// File: rtl/audio_mixer_multi.sv
// N-channel weighted audio mixer: ZX-Uno volume/control registers, a
// time-multiplexed accumulator with saturation, and a first-order sigma-delta DAC.
module audio_mixer_multi #(
  parameter int         NCHAN    = 4,
  parameter int         WIDTH    = 8,
  parameter int         VOLBITS  = 4,
  parameter logic [7:0] REGBASE  = 8'hC0,
  parameter int         BEEP_LVL = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             zxuno_addr,
  input  logic                   zxuno_regrd,
  input  logic                   zxuno_regwr,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   oe_n,
  input  logic [NCHAN*WIDTH-1:0] ch_in,
  input  logic                   spk,
  input  logic                   ear,
  input  logic                   mic,
  output logic [WIDTH-1:0]       mix,
  output logic                   mix_strobe,
  output logic                   audio_out
);

  localparam int STEPW = $clog2(NCHAN + 2);
  localparam int ACCW  = WIDTH + $clog2(NCHAN + 2);
  localparam int PRODW = WIDTH + VOLBITS;
  localparam logic [STEPW-1:0] BEEP_STEP = STEPW'(NCHAN);
  localparam logic [STEPW-1:0] LAST_STEP = STEPW'(NCHAN + 1);
  localparam logic [ACCW-1:0]  MIX_MAX   = ACCW'((1 << WIDTH) - 1);
  localparam logic [7:0]       CTRL_ADDR = REGBASE + 8'(NCHAN);

  logic [STEPW-1:0]   step_r;
  logic [ACCW-1:0]    acc_r;
  logic [WIDTH-1:0]   mix_r;
  logic               mix_strobe_r;
  logic [WIDTH:0]     sd_r;
  logic               audio_out_r;
  logic [VOLBITS-1:0] vol_r [NCHAN];
  logic [1:0]         ctrl_r;

  logic [WIDTH-1:0]   samp_s;
  logic [VOLBITS-1:0] gain_s;
  logic [PRODW-1:0]   prod_s;
  logic [ACCW-1:0]    term_s;
  logic [ACCW-1:0]    beep_s;
  logic [ACCW-1:0]    sum_s;
  logic               hit_s;
  logic [7:0]         rdata_s;
  logic               unused_s;

  // Select the current step's channel and volume, and form the weighted/beeper term.
  always_comb begin
    samp_s = '0;
    gain_s = '0;
    for (int i = 0; i < NCHAN; i++) begin
      samp_s = samp_s | (ch_in[i*WIDTH +: WIDTH] & {WIDTH{step_r == STEPW'(i)}});
      gain_s = gain_s | (vol_r[i] & {VOLBITS{step_r == STEPW'(i)}});
    end
    prod_s = PRODW'(samp_s) * PRODW'(gain_s);
    term_s = ACCW'(prod_s[PRODW-1:VOLBITS]);
    if (ctrl_r[1]) begin
      beep_s = '0;
    end else begin
      beep_s = (spk ? ACCW'(BEEP_LVL)     : ACCW'(0))
             + (ear ? ACCW'(BEEP_LVL / 4) : ACCW'(0))
             + (mic ? ACCW'(BEEP_LVL / 8) : ACCW'(0));
    end
    sum_s = acc_r + ((step_r == BEEP_STEP) ? beep_s : term_s);
  end

  // Frame sequencer: step 0 restarts the sum, the last step publishes the saturated mix.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_r       <= '0;
      acc_r        <= '0;
      mix_r        <= '0;
      mix_strobe_r <= 1'b0;
    end else if (step_r == LAST_STEP) begin
      step_r       <= '0;
      mix_strobe_r <= 1'b1;
      mix_r        <= ctrl_r[0] ? WIDTH'(0)
                    : ((acc_r > MIX_MAX) ? MIX_MAX[WIDTH-1:0] : acc_r[WIDTH-1:0]);
    end else begin
      step_r       <= step_r + STEPW'(1);
      mix_strobe_r <= 1'b0;
      acc_r        <= (step_r == STEPW'(0)) ? term_s : sum_s;
    end
  end

  // Volume and control register writes from the ZX-Uno data port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_r <= 2'b00;
      for (int i = 0; i < NCHAN; i++) vol_r[i] <= '1;
    end else if (zxuno_regwr) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (zxuno_addr == REGBASE + 8'(i)) vol_r[i] <= din[VOLBITS-1:0];
      end
      if (zxuno_addr == CTRL_ADDR) ctrl_r <= din[1:0];
    end else begin
      ctrl_r <= ctrl_r;
    end
  end

  // First-order sigma-delta: the carry out of the error accumulator is the bitstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sd_r        <= '0;
      audio_out_r <= 1'b0;
    end else begin
      sd_r        <= {1'b0, sd_r[WIDTH-1:0]} + {1'b0, mix_r};
      audio_out_r <= sd_r[WIDTH];
    end
  end

  // Combinational register read-back; the bus is released outside our address window.
  always_comb begin
    hit_s   = (zxuno_addr == CTRL_ADDR);
    rdata_s = {6'b000000, ctrl_r} & {8{zxuno_addr == CTRL_ADDR}};
    for (int i = 0; i < NCHAN; i++) begin
      hit_s   = hit_s | (zxuno_addr == REGBASE + 8'(i));
      rdata_s = rdata_s | (8'(vol_r[i]) & {8{zxuno_addr == REGBASE + 8'(i)}});
    end
    if (zxuno_regrd && hit_s) begin
      dout = rdata_s;
      oe_n = 1'b0;
    end else begin
      dout = 8'hFF;
      oe_n = 1'b1;
    end
  end

  assign unused_s   = ^{din, prod_s};
  assign mix        = mix_r;
  assign mix_strobe = mix_strobe_r;
  assign audio_out  = audio_out_r;

endmodule

// File: tb/tb_audio_mixer_multi.sv
// Self-checking bench for audio_mixer_multi: directed scenarios plus randomized
// frames checked against an arithmetic model of the mix.
module tb_audio_mixer_multi;
  localparam int NCHAN = 4;
  localparam int WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [7:0]             zxuno_addr = 8'h00;
  logic                   zxuno_regrd = 1'b0;
  logic                   zxuno_regwr = 1'b0;
  logic [7:0]             din = 8'h00;
  logic [7:0]             dout;
  logic                   oe_n;
  logic [NCHAN*WIDTH-1:0] ch_in = '0;
  logic                   spk = 1'b0, ear = 1'b0, mic = 1'b0;
  logic [WIDTH-1:0]       mix;
  logic                   mix_strobe;
  logic                   audio_out;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int ch_m [NCHAN];
  int vol_m [NCHAN];
  int ctrl_m = 0;

  audio_mixer_multi dut (
    .clk(clk), .rst_n(rst_n), .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .din(din), .dout(dout), .oe_n(oe_n), .ch_in(ch_in),
    .spk(spk), .ear(ear), .mic(mic), .mix(mix), .mix_strobe(mix_strobe),
    .audio_out(audio_out)
  );

  always #5 clk = ~clk;

  function automatic int model_mix();
    int s = 0;
    for (int i = 0; i < NCHAN; i++) s += (ch_m[i] * vol_m[i]) / 16;
    if ((ctrl_m & 2) == 0) s += (spk ? 64 : 0) + (ear ? 16 : 0) + (mic ? 8 : 0);
    if ((ctrl_m & 1) != 0) return 0;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NCHAN; i++) ch_in[i*WIDTH +: WIDTH] = WIDTH'(ch_m[i]);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    zxuno_addr = a; din = d; zxuno_regwr = 1'b1;
    @(negedge clk);
    zxuno_regwr = 1'b0; din = 8'h00;
  endtask

  task automatic set_vol(input int i, input int v);
    write_reg(8'hC0 + 8'(i), 8'(v));
    vol_m[i] = v;
  endtask

  task automatic set_ctrl(input int c);
    write_reg(8'hC4, 8'(c));
    ctrl_m = c;
  endtask

  // Returns the number of clocks until the next strobe, 0 on timeout.
  task automatic wait_strobe(output int clocks);
    clocks = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mix_strobe === 1'b1) begin
        clocks = k;
        break;
      end
    end
    if (clocks == 0) begin
      chk_cnt++;
      $display("FAIL strobe_timeout: no mix_strobe within 20 clocks");
    end
  endtask

  task automatic settle();
    int c;
    wait_strobe(c);
    wait_strobe(c);
  endtask

  task automatic test_reset();
    int c;
    rst_n = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin ch_m[i] = 0; vol_m[i] = 15; end
    ctrl_m = 0;
    drive_inputs();
    repeat (3) @(negedge clk);
    chk_cnt++; if (mix !== 8'd0 || audio_out !== 1'b0 || mix_strobe !== 1'b0)
      $display("FAIL reset_outputs: mix=%0d audio_out=%b strobe=%b expected 0/0/0", mix, audio_out, mix_strobe);
    else pass_cnt++;
    zxuno_regrd = 1'b1;
    for (int i = 0; i < NCHAN; i++) begin
      zxuno_addr = 8'hC0 + 8'(i); #1;
      chk_cnt++; if (dout !== 8'h0F || oe_n !== 1'b0)
        $display("FAIL reset_vol_read: addr=%h dout=%h oe_n=%b expected 0f/0", zxuno_addr, dout, oe_n);
      else pass_cnt++;
    end
    zxuno_addr = 8'hC4; #1;
    chk_cnt++; if (dout !== 8'h00 || oe_n !== 1'b0)
      $display("FAIL reset_ctrl_read: dout=%h oe_n=%b expected 00/0", dout, oe_n);
    else pass_cnt++;
    zxuno_addr = 8'hC5; #1;
    chk_cnt++; if (dout !== 8'hFF || oe_n !== 1'b1)
      $display("FAIL read_above_window: dout=%h oe_n=%b expected ff/1", dout, oe_n);
    else pass_cnt++;
    zxuno_addr = 8'hBF; #1;
    chk_cnt++; if (oe_n !== 1'b1)
      $display("FAIL read_below_window: oe_n=%b expected 1", oe_n);
    else pass_cnt++;
    zxuno_regrd = 1'b0; zxuno_addr = 8'hC0; #1;
    chk_cnt++; if (dout !== 8'hFF || oe_n !== 1'b1)
      $display("FAIL read_no_strobe: dout=%h oe_n=%b expected ff/1", dout, oe_n);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_strobe(c);
    chk_cnt++; if (c != 6)
      $display("FAIL first_strobe_latency: got %0d clocks expected 6", c);
    else pass_cnt++;
    chk_cnt++; if (mix !== 8'd0 || audio_out !== 1'b0)
      $display("FAIL first_mix_zero: mix=%0d audio_out=%b expected 0/0", mix, audio_out);
    else pass_cnt++;
  endtask

  task automatic test_weighting();
    ch_m[0] = 200; drive_inputs();
    set_vol(0, 8);
    settle();
    chk_cnt++; if (mix !== 8'd100)
      $display("FAIL weight_vol8: mix=%0d expected 100", mix);
    else pass_cnt++;
    set_vol(0, 15);
    settle();
    chk_cnt++; if (mix !== 8'd187)
      $display("FAIL weight_vol15: mix=%0d expected 187", mix);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NCHAN; i++) begin ch_m[i] = 255; set_vol(i, 15); end
    spk = 1'b1; drive_inputs();
    settle();
    chk_cnt++; if (mix !== 8'd255)
      $display("FAIL saturation: mix=%0d expected 255", mix);
    else pass_cnt++;
  endtask

  task automatic test_mute_beeper();
    int c;
    int ones;
    set_ctrl(1);
    settle();
    for (int f = 0; f < 3; f++) begin
      wait_strobe(c);
      chk_cnt++; if (c != 6 || mix !== 8'd0)
        $display("FAIL mute_frame: period=%0d mix=%0d expected 6/0", c, mix);
      else pass_cnt++;
    end
    ones = 0;
    for (int k = 0; k < 12; k++) begin @(negedge clk); ones += int'(audio_out); end
    chk_cnt++; if (ones != 0)
      $display("FAIL mute_audio_idle: ones=%0d expected 0", ones);
    else pass_cnt++;
    for (int i = 0; i < NCHAN; i++) ch_m[i] = 0;
    drive_inputs(); spk = 1'b1;
    set_ctrl(2);
    settle();
    chk_cnt++; if (mix !== 8'd0)
      $display("FAIL beeper_disable: mix=%0d expected 0", mix);
    else pass_cnt++;
    set_ctrl(0);
    settle();
    chk_cnt++; if (mix !== 8'd64)
      $display("FAIL beeper_spk: mix=%0d expected 64", mix);
    else pass_cnt++;
    spk = 1'b0;
  endtask

  task automatic test_midframe_vol();
    int c;
    int exp_old;
    int exp_new;
    for (int i = 0; i < NCHAN; i++) ch_m[i] = 0;
    ch_m[2] = 160; drive_inputs();
    set_vol(0, 15);
    set_vol(2, 8);
    settle();
    exp_old = model_mix();
    wait_strobe(c);
    @(negedge clk);
    @(negedge clk);
    ch_m[0] = 100; drive_inputs();
    set_vol(2, 15);
    exp_new = model_mix();
    wait_strobe(c);
    chk_cnt++; if (mix !== 8'(exp_old))
      $display("FAIL midframe_old_frame: mix=%0d expected %0d", mix, exp_old);
    else pass_cnt++;
    wait_strobe(c);
    chk_cnt++; if (mix !== 8'(exp_new))
      $display("FAIL midframe_next_frame: mix=%0d expected %0d", mix, exp_new);
    else pass_cnt++;
  endtask

  task automatic test_sigma_delta();
    int ones;
    int alt_bad;
    logic prev;
    for (int i = 0; i < NCHAN; i++) ch_m[i] = 0;
    ch_m[0] = 128; drive_inputs();
    set_vol(0, 8);
    spk = 1'b1;
    settle();
    repeat (4) @(negedge clk);
    ones = 0; alt_bad = 0; prev = audio_out;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      ones += int'(audio_out);
      if (audio_out === prev) alt_bad++;
      prev = audio_out;
    end
    chk_cnt++; if (ones != 16 || alt_bad != 0)
      $display("FAIL sd_half: ones=%0d repeats=%0d expected 16/0", ones, alt_bad);
    else pass_cnt++;
    ch_m[0] = 0; drive_inputs();
    settle();
    repeat (4) @(negedge clk);
    ones = 0;
    for (int k = 0; k < 32; k++) begin @(negedge clk); ones += int'(audio_out); end
    chk_cnt++; if (ones != 8)
      $display("FAIL sd_quarter: ones=%0d expected 8", ones);
    else pass_cnt++;
    spk = 1'b0;
  endtask

  task automatic test_random();
    int exp_m;
    int r;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < NCHAN; i++) begin
        ch_m[i] = int'($urandom_range(255, 0));
        set_vol(i, int'($urandom_range(15, 0)));
      end
      set_ctrl(int'($urandom_range(3, 0)));
      spk = 1'($urandom_range(1, 0));
      ear = 1'($urandom_range(1, 0));
      mic = 1'($urandom_range(1, 0));
      drive_inputs();
      settle();
      exp_m = model_mix();
      chk_cnt++; if (mix !== 8'(exp_m))
        $display("FAIL random_mix[%0d]: mix=%0d expected %0d", it, mix, exp_m);
      else pass_cnt++;
      r = int'($urandom_range(NCHAN, 0));
      zxuno_regrd = 1'b1; zxuno_addr = 8'hC0 + 8'(r); #1;
      exp_m = (r == NCHAN) ? ctrl_m : vol_m[r];
      chk_cnt++; if (dout !== 8'(exp_m) || oe_n !== 1'b0)
        $display("FAIL random_read[%0d]: addr=%h dout=%h oe_n=%b expected %h/0", it, zxuno_addr, dout, oe_n, 8'(exp_m));
      else pass_cnt++;
      zxuno_regrd = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    int exp_m;
    int bad;
    set_ctrl(0);
    settle();
    exp_m = model_mix();
    bad = 0;
    for (int f = 0; f < 8; f++) begin
      wait_strobe(c);
      if (c != 6 || mix !== 8'(exp_m)) bad++;
    end
    chk_cnt++; if (bad != 0)
      $display("FAIL back_to_back: bad_frames=%0d expected 0 (mix=%0d exp=%0d)", bad, mix, exp_m);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int c;
    int exp_m;
    wait_strobe(c);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NCHAN; i++) vol_m[i] = 15;
    ctrl_m = 0;
    exp_m = model_mix();
    wait_strobe(c);
    chk_cnt++; if (c != 6 || mix !== 8'(exp_m))
      $display("FAIL reset_midframe: period=%0d mix=%0d expected 6/%0d", c, mix, exp_m);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_weighting();
    test_saturation();
    test_mute_beeper();
    test_midframe_vol();
    test_sigma_delta();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/audio_mixer_multi.md
# audio_mixer_multi

Parametrised N-channel audio mixer for the Spectrum core. It replaces the fixed two-AY mixer and takes NCHAN unsigned PSG/DAC sample channels plus the ULA beeper bits (spk, ear, mic). Each channel has a volume register in the ZX-Uno register space. The block time-multiplexes the weighted sum through one accumulator, saturates the result, and drives a first-order sigma-delta 1-bit output.

## Interface
Parameters:
- NCHAN, 4, number of sample channels, legal range 1..8
- WIDTH, 8, sample width and mix width in bits
- VOLBITS, 4, volume register width, legal range 1..8
- REGBASE, 8'hC0, ZX-Uno address of channel 0 volume; channel i is at REGBASE+i; control register is at REGBASE+NCHAN
- BEEP_LVL, 64, beeper contribution when spk=1; ear adds BEEP_LVL/4, mic adds BEEP_LVL/8

Ports:
- clk  in  1  system clock (28 MHz)
- rst_n  in  1  reset, synchronous, active-low
- zxuno_addr  in  8  current ZX-Uno register address
- zxuno_regrd  in  1  read strobe on the ZX-Uno data port
- zxuno_regwr  in  1  write strobe on the ZX-Uno data port
- din  in  8  CPU data out
- dout  out  8  register read data
- oe_n  out  1  low when dout is valid for the CPU bus
- ch_in  in  NCHAN*WIDTH  channel samples, unsigned; channel i is at bits [i*WIDTH +: WIDTH]
- spk, ear, mic  in  1 each  beeper sources
- mix  out  WIDTH  last completed saturated mix
- mix_strobe  out  1  one-cycle pulse when mix updates
- audio_out  out  1  sigma-delta output

## Operation
- Register file:
  - vol[i] is VOLBITS wide; reset value is all ones.
  - ctrl is 2 bits; reset value is 0. ctrl[0] = global mute, ctrl[1] = beeper disable.
  - Write: zxuno_regwr=1 and the address matches loads din[VOLBITS-1:0] (or din[1:0] for ctrl) on that clock.
  - Read: combinational. oe_n=0 only while zxuno_regrd=1 and zxuno_addr is in REGBASE..REGBASE+NCHAN. dout returns the value zero-extended. dout=8'hFF and oe_n=1 otherwise.
- Sequencer: a step counter runs 0..NCHAN+1 and wraps to 0; it never stalls.
  - Step 0: acc is loaded with term(0). It is not added to the previous value.
  - Steps 1..NCHAN-1: acc += term(i), where term(i) = (ch_in[i] * vol[i]) >> VOLBITS, computed at full width (WIDTH+VOLBITS) before the shift.
  - Step NCHAN: acc += beep, where beep = (spk?BEEP_LVL:0) + (ear?BEEP_LVL/4:0) + (mic?BEEP_LVL/8:0). beep is 0 if ctrl[1]=1.
  - Step NCHAN+1: mix <= ctrl[0] ? 0 : min(acc, 2^WIDTH-1), and mix_strobe=1.
- acc width is WIDTH+clog2(NCHAN+2) so that it never wraps.
- Inputs are sampled only in their own step. Changes in other steps are ignored until the next frame.
- A volume write in the same clock as that channel's step uses the old value; the new value applies from the next frame.
- Sigma-delta runs every clock: sd <= {1'b0, sd[WIDTH-1:0]} + mix, with sd being WIDTH+1 bits wide; audio_out <= sd[WIDTH] (registered).

## Timing
- Frame length is NCHAN+2 clocks; mix_strobe period is NCHAN+2.
- Latency: a sample sampled at step i reaches mix NCHAN+1-i clocks later, and affects audio_out from the following clock.
- Reset (rst_n=0 at a clock edge) clears step, acc, mix, sd, audio_out, mix_strobe and ctrl, and sets vol to all ones. This applies mid-frame too: the partial sum is discarded and the first mix_strobe comes NCHAN+2 clocks after rst_n is released.
- Mute does not stop the sequencer or the strobe.
- For mix=0, audio_out stays 0. For mix=M, the long-run duty of audio_out is exactly M/2^WIDTH.

## Test plan
- Reset, defaults:
  - Reset, then read REGBASE → dout=8'h0F, oe_n=0.
  - Read REGBASE+NCHAN → 8'h00.
  - Read REGBASE+NCHAN+1 → oe_n=1.
  - After reset: mix=0, audio_out=0, first mix_strobe 6 clocks after release (NCHAN=4).
- Weighting:
  - Set ch0=200, vol0=8; others and beeper 0 → mix=100.
  - Set vol0=15 → mix=187.
- Saturation: all four channels 255 at vol 15, spk=1 → mix=255.
- Mute and beeper:
  - Set ctrl=1 → mix=0 while mix_strobe keeps its 6-clock period.
  - Set ctrl=2 with spk=1 and channels 0 → mix=0.
  - Set ctrl=0 → mix=64.
- Mid-frame volume write: write vol2 in the same clock as step 2 → that frame uses the old vol2; the next frame uses the new value.
- Sigma-delta: hold mix=128 → audio_out toggles 0,1,0,1… (exactly 50%). Hold mix=64 → one 1 in every 4 clocks.
